// File: rtl/online_divider.sv
`default_nettype none
// ============================================================================
// Module   : online_divider
// Brief    : Radix-2 MSD-first online divider (online delay 4), N_DIGITS
//            quotient digits per operation, operations run back-to-back.
// Revision : 1.0  initial release
// ============================================================================
module online_divider #(
    parameter int N_DIGITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] q_value,
    input  logic [1:0] d_value,
    output logic [3:0] q_plus_dis,
    output logic [3:0] q_minus_dis,
    output logic [3:0] d_plus_dis,
    output logic [3:0] d_minus_dis,
    output logic       read_indicator,
    output logic [1:0] STATE,
    output logic [8:0] cnt_master_dis,
    output logic [6:0] computation_cycle_dis,
    output logic [3:0] q_plus_sel_dis,
    output logic [3:0] q_minus_sel_dis,
    output logic [5:0] v_upper_plus_dis,
    output logic [5:0] v_upper_minus_dis,
    output logic [3:0] v_plus_dis,
    output logic [3:0] v_minus_dis,
    output logic [1:0] cin,
    output logic [1:0] cout,
    output logic       carry_feedback,
    output logic       carry_propogate
);
    localparam int FRAC = N_DIGITS + 4;
    localparam int W    = FRAC + 3;
    localparam logic signed [W-1:0] c_ONE  = W'(1) << FRAC;
    localparam logic signed [W-1:0] c_HALF = c_ONE >>> 1;
    localparam logic signed [W-1:0] c_TWO  = c_ONE <<< 1;
    localparam logic [7:0] c_DELAY  = 8'd4;
    localparam logic [7:0] c_N      = 8'(N_DIGITS);
    localparam logic [7:0] c_LAST   = 8'(N_DIGITS + 4);
    localparam logic [7:0] c_RI_OFF = 8'(N_DIGITS - 2);
    localparam logic [7:0] c_LO_K   = 8'(FRAC - 3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_INIT  = 2'b01,
        ST_ITER  = 2'b10,
        ST_FLUSH = 2'b11
    } state_t;

    state_t r_state, w_state_nxt;

    logic                r_cap;
    logic [7:0]          r_c;
    logic signed [W-1:0] r_d, r_q, r_w;
    logic [3:0]          r_x_lo;

    logic                w_iter, w_j_valid;
    logic [7:0]          w_c_nxt;
    logic signed [1:0]   w_xk, w_dk, w_qsel, w_prod;
    logic signed [W-1:0] w_pow_k, w_pow_j, w_d_nxt, w_v, w_w_nxt, w_q_nxt;
    logic                w_ovf;
    logic [3:0]          w_pow_lo, w_x_lo_nxt;

    function automatic logic signed [1:0] f_decode(input logic [1:0] e);
        case (e)
            2'b10:   return 2'sb01;
            2'b01:   return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

    function automatic logic [1:0] f_encode(input logic signed [1:0] s);
        case (s)
            2'sb01:  return 2'b10;
            2'sb11:  return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic signed [W-1:0] f_scale(input logic signed [1:0] s,
                                                     input logic signed [W-1:0] a);
        case (s)
            2'sb01:  return a;
            2'sb11:  return -a;
            default: return '0;
        endcase
    endfunction

    // Flush iterations feed zero digits and ignore the input pins.
    assign w_iter    = r_cap | (r_state == ST_FLUSH);
    assign w_xk      = r_cap ? f_decode(q_value) : 2'sb00;
    assign w_dk      = r_cap ? f_decode(d_value) : 2'sb00;
    assign w_c_nxt   = r_c + 8'd1;
    assign w_j_valid = (r_c >= c_DELAY);
    assign w_pow_k   = c_ONE >> w_c_nxt;
    assign w_pow_j   = c_ONE >> (w_c_nxt - c_DELAY);
    assign w_d_nxt   = r_d + f_scale(w_dk, w_pow_k);
    assign w_v       = (r_w <<< 1) + ((f_scale(w_xk, c_ONE) - f_scale(w_dk, r_q)) >>> 4);
    assign w_w_nxt   = w_v - f_scale(w_qsel, w_d_nxt);
    assign w_q_nxt   = r_q + f_scale(w_qsel, w_pow_j);
    assign w_ovf     = (w_v >= c_TWO) || (w_v <= -c_TWO);

    // Selection on v floored to 2 fractional bits reduces to plain thresholds.
    always_comb begin
        w_qsel = 2'sb00;
        if (w_j_valid) begin
            if (w_v >= c_HALF)       w_qsel = 2'sb01;
            else if (w_v < -c_HALF)  w_qsel = 2'sb11;
        end
    end

    always_comb begin
        w_prod = 2'sb00;
        if (w_qsel != 2'sb00 && w_dk != 2'sb00)
            w_prod = (w_qsel == w_dk) ? 2'sb01 : 2'sb11;
    end

    // Only the low nibble of X is exported; carries never move downward.
    always_comb begin
        w_pow_lo = 4'd0;
        if (w_c_nxt >= c_LO_K && w_c_nxt <= c_LAST)
            w_pow_lo = 4'b1000 >> (w_c_nxt - c_LO_K);
        case (w_xk)
            2'sb01:  w_x_lo_nxt = r_x_lo + w_pow_lo;
            2'sb11:  w_x_lo_nxt = r_x_lo - w_pow_lo;
            default: w_x_lo_nxt = r_x_lo;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_INIT;
            default: begin
                if (w_iter) begin
                    if (w_c_nxt == c_LAST)       w_state_nxt = ST_IDLE;
                    else if (w_c_nxt >= c_N)     w_state_nxt = ST_FLUSH;
                    else if (w_c_nxt >= c_DELAY) w_state_nxt = ST_ITER;
                    else                         w_state_nxt = ST_INIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap            <= 1'b0;
            r_c              <= '0;
            r_d              <= '0;
            r_q              <= '0;
            r_w              <= '0;
            r_x_lo           <= '0;
            read_indicator   <= 1'b0;
            cnt_master_dis   <= '0;
            q_plus_dis       <= '0;
            q_minus_dis      <= '0;
            d_plus_dis       <= '0;
            d_minus_dis      <= '0;
            q_plus_sel_dis   <= '0;
            q_minus_sel_dis  <= '0;
            v_upper_plus_dis <= '0;
            cin              <= '0;
            cout             <= '0;
            carry_feedback   <= 1'b0;
            carry_propogate  <= 1'b0;
        end else begin
            cnt_master_dis  <= cnt_master_dis + 9'd1;
            r_cap           <= read_indicator;
            carry_propogate <= 1'b0;
            if (r_state == ST_IDLE) begin
                read_indicator   <= 1'b1;
                r_c              <= '0;
                r_d              <= '0;
                r_q              <= '0;
                r_w              <= '0;
                r_x_lo           <= '0;
                q_plus_dis       <= '0;
                q_minus_dis      <= '0;
                d_plus_dis       <= '0;
                d_minus_dis      <= '0;
                q_plus_sel_dis   <= '0;
                q_minus_sel_dis  <= '0;
                v_upper_plus_dis <= '0;
                cin              <= '0;
                cout             <= '0;
                carry_feedback   <= 1'b0;
            end else if (w_iter) begin
                r_c              <= w_c_nxt;
                r_d              <= w_d_nxt;
                r_q              <= w_q_nxt;
                r_w              <= w_w_nxt;
                r_x_lo           <= w_x_lo_nxt;
                v_upper_plus_dis <= w_v[W-1:W-6];
                cin              <= f_encode(w_qsel);
                cout             <= f_encode(w_prod);
                if (w_ovf)
                    carry_feedback <= 1'b1;
                // Request window closes so that exactly N_DIGITS pairs arrive.
                if (r_c == c_RI_OFF)
                    read_indicator <= 1'b0;
                if (r_cap) begin
                    q_plus_dis  <= {q_plus_dis[2:0],  q_value[1]};
                    q_minus_dis <= {q_minus_dis[2:0], q_value[0]};
                    d_plus_dis  <= {d_plus_dis[2:0],  d_value[1]};
                    d_minus_dis <= {d_minus_dis[2:0], d_value[0]};
                end
                if (w_j_valid) begin
                    carry_propogate <= 1'b1;
                    q_plus_sel_dis  <= {q_plus_sel_dis[2:0],  (w_qsel == 2'sb01)};
                    q_minus_sel_dis <= {q_minus_sel_dis[2:0], (w_qsel == 2'sb11)};
                end
            end
        end
    end

    assign STATE                 = r_state;
    assign computation_cycle_dis = r_c[6:0];
    assign v_upper_minus_dis     = r_w[W-1:W-6];
    assign v_plus_dis            = r_x_lo;
    assign v_minus_dis           = r_d[3:0];

endmodule
`default_nettype wire

// File: tb/tb_online_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_online_divider
// Brief    : Self-checking bench for online_divider against a real-valued model.
// Revision : 1.0  initial release
// ============================================================================
module tb_online_divider;
    localparam int N     = 16;
    localparam int OPLEN = N + 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] q_value, d_value;
    logic [3:0] q_plus_dis, q_minus_dis, d_plus_dis, d_minus_dis;
    logic       read_indicator;
    logic [1:0] STATE;
    logic [8:0] cnt_master_dis;
    logic [6:0] computation_cycle_dis;
    logic [3:0] q_plus_sel_dis, q_minus_sel_dis;
    logic [5:0] v_upper_plus_dis, v_upper_minus_dis;
    logic [3:0] v_plus_dis, v_minus_dis;
    logic [1:0] cin, cout;
    logic       carry_feedback, carry_propogate;

    always #5 clk = ~clk;

    online_divider #(.N_DIGITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .q_value(q_value), .d_value(d_value),
        .q_plus_dis(q_plus_dis), .q_minus_dis(q_minus_dis),
        .d_plus_dis(d_plus_dis), .d_minus_dis(d_minus_dis),
        .read_indicator(read_indicator), .STATE(STATE),
        .cnt_master_dis(cnt_master_dis), .computation_cycle_dis(computation_cycle_dis),
        .q_plus_sel_dis(q_plus_sel_dis), .q_minus_sel_dis(q_minus_sel_dis),
        .v_upper_plus_dis(v_upper_plus_dis), .v_upper_minus_dis(v_upper_minus_dis),
        .v_plus_dis(v_plus_dis), .v_minus_dis(v_minus_dis),
        .cin(cin), .cout(cout),
        .carry_feedback(carry_feedback), .carry_propogate(carry_propogate)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    int         xs [N];
    int         ds [N];
    logic [1:0] xenc [N];
    logic [1:0] denc [N];
    int         exp_q [N];
    logic       exp_flag;
    int         idx = 0;
    logic       ri_seen = 1'b0;
    logic [8:0] cnt_exp = '0;
    real        target;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] enc_in(input int s);
        if (s > 0) return 2'b10;
        if (s < 0) return 2'b01;
        return ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [1:0] enc_q(input int s);
        if (s > 0) return 2'b10;
        if (s < 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_state(input int t);
        if (t <= 5)     return 2'b01;
        if (t <= N + 1) return 2'b10;
        if (t <= N + 5) return 2'b11;
        return 2'b00;
    endfunction

    // One clock: source answers the request seen at this edge, outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        cnt_exp = rst_n ? cnt_exp + 9'd1 : 9'd0;
        if (rst_n && ri_seen && idx < N) begin
            q_value = xenc[idx];
            d_value = denc[idx];
            idx++;
        end else begin
            q_value = 2'($urandom);
            d_value = 2'($urandom);
        end
        @(negedge clk);
        ri_seen = read_indicator;
    endtask

    // Quotient digits from the arithmetic definition, in real arithmetic.
    task automatic model();
        real dv = 0.0, qv = 0.0, w = 0.0, v, vh, sk = 1.0, sj = 1.0;
        int  xk, dk, q;
        exp_flag = 1'b0;
        for (int k = 1; k <= N + 4; k++) begin
            xk = (k <= N) ? xs[k-1] : 0;
            dk = (k <= N) ? ds[k-1] : 0;
            sk = sk / 2.0;
            dv = dv + dk * sk;
            v  = 2.0 * w + (xk - qv * dk) / 16.0;
            if (v >= 2.0 || v <= -2.0) exp_flag = 1'b1;
            if (k <= 4) begin
                w = v;
            end else begin
                sj = sj / 2.0;
                vh = $floor(v * 4.0) / 4.0;
                q  = (vh >= 0.5) ? 1 : ((vh <= -0.75) ? -1 : 0);
                w  = v - q * dv;
                qv = qv + q * sj;
                exp_q[k-5] = q;
            end
        end
    endtask

    // Starts in an IDLE cycle, ends in the IDLE cycle of the following op.
    task automatic run_op(input bit chk_digits, input bit chk_vzero, input bit chk_val);
        int  pulses = 0;
        int  got [$];
        real val = 0.0, wt = 0.5, err;
        logic [3:0] ex_xp, ex_dm, ex_sp, ex_sm;
        for (int i = 0; i < N; i++) begin
            xenc[i] = enc_in(xs[i]);
            denc[i] = enc_in(ds[i]);
        end
        model();
        idx = 0;
        for (int t = 1; t <= OPLEN; t++) begin
            tick();
            chk("state", STATE, exp_state(t));
            chk("read_ind", read_indicator, (t <= N));
            chk("ccycle", computation_cycle_dis, (t <= 2) ? 0 : t - 2);
            chk("cnt_master", cnt_master_dis, cnt_exp);
            chk("qvalid", carry_propogate, (t >= 7));
            if (t == 1) chk("op_clear", {q_plus_sel_dis, q_minus_sel_dis, carry_feedback}, 0);
            if (chk_vzero) chk("v_upper_zero", {v_upper_plus_dis, v_upper_minus_dis}, 0);
            if (carry_propogate) begin
                got.push_back((cin == 2'b10) ? 1 : ((cin == 2'b01) ? -1 : 0));
                if (chk_digits && pulses < N) chk("qdigit", cin, enc_q(exp_q[pulses]));
                pulses++;
            end
        end
        chk("npulses", pulses, N);
        chk("err_flag", carry_feedback, exp_flag);
        if (chk_digits) begin
            for (int i = 0; i < 4; i++) begin
                ex_xp[i] = xenc[N-1-i][1];
                ex_dm[i] = denc[N-1-i][0];
                ex_sp[i] = (exp_q[N-1-i] > 0);
                ex_sm[i] = (exp_q[N-1-i] < 0);
            end
            chk("x_plus_hist", q_plus_dis, ex_xp);
            chk("d_minus_hist", d_minus_dis, ex_dm);
            chk("qsel_hist", {q_plus_sel_dis, q_minus_sel_dis}, {ex_sp, ex_sm});
        end
        if (chk_val) begin
            foreach (got[i]) begin
                val = val + got[i] * wt;
                wt  = wt / 2.0;
            end
            err = val - target;
            if (err < 0.0) err = -err;
            chk("qvalue", (err <= 1.0 / 65536.0), 1'b1);
        end
    endtask

    task automatic clear_digits();
        for (int i = 0; i < N; i++) begin
            xs[i] = 0;
            ds[i] = 0;
        end
    endtask

    task automatic rand_digits();
        int dint, xmag, sgn;
        dint = int'($urandom_range(32768, 65535));
        xmag = int'($urandom_range(0, 32'(dint / 2 - 1)));
        sgn  = ($urandom_range(0, 1) == 1) ? -1 : 1;
        for (int i = 0; i < N; i++) begin
            ds[i] = (dint >> (N - 1 - i)) & 1;
            xs[i] = sgn * ((xmag >> (N - 1 - i)) & 1);
        end
        // Redundant recoding (0,a) -> (a,-a) keeps the value, exercises mixed-sign digits.
        for (int i = N - 1; i >= 1; i--) begin
            if (xs[i-1] == 0 && xs[i] != 0 && $urandom_range(0, 1) == 1) begin
                xs[i-1] = xs[i];
                xs[i]   = -xs[i];
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        q_value = 2'b00;
        d_value = 2'b00;
        tick();
        tick();
        chk("rst_state", STATE, 2'b00);
        chk("rst_read_ind", read_indicator, 1'b0);
        chk("rst_cnt", cnt_master_dis, 9'd0);
        chk("rst_ccycle", computation_cycle_dis, 7'd0);
        chk("rst_flags", {carry_feedback, carry_propogate, cin, cout}, 0);
        chk("rst_hist", {q_plus_dis, q_minus_dis, d_plus_dis, d_minus_dis,
                         q_plus_sel_dis, q_minus_sel_dis}, 0);
        chk("rst_res", {v_upper_plus_dis, v_upper_minus_dis, v_plus_dis, v_minus_dis}, 0);
        rst_n = 1'b1;

        clear_digits(); xs[1] = 1;  ds[0] = 1;             target = 0.5;
        run_op(1'b1, 1'b0, 1'b1);
        clear_digits(); ds[0] = 1;                         target = 0.0;
        run_op(1'b1, 1'b1, 1'b1);
        clear_digits(); xs[1] = -1; ds[0] = 1; ds[1] = 1;  target = -1.0 / 3.0;
        run_op(1'b1, 1'b0, 1'b1);
        clear_digits(); xs[0] = 1; xs[1] = 1; xs[2] = 1; ds[0] = 1;
        run_op(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            rand_digits();
            run_op(1'b1, 1'b0, 1'b0);
        end

        rand_digits();
        for (int i = 0; i < N; i++) begin
            xenc[i] = enc_in(xs[i]);
            denc[i] = enc_in(ds[i]);
        end
        idx = 0;
        for (int t = 1; t <= 10; t++) tick();
        chk("pre_abort_state", STATE, 2'b10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_state", STATE, 2'b00);
        chk("abort_ccycle", computation_cycle_dis, 7'd0);
        chk("abort_cnt", cnt_master_dis, 9'd0);
        chk("abort_outs", {read_indicator, carry_propogate, q_plus_sel_dis}, 0);
        for (int r = 0; r < 2; r++) begin
            rand_digits();
            run_op(1'b1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
